// File: rtl/ahbslv_mem.sv
// AHB slave backed by a word-organised memory. Serves SINGLE/INCR bursts beat by beat,
// with optional wait states, byte/half/word write lanes and a two-cycle ERROR response.
module ahbslv_mem #(
  parameter int P_ADDR_W = 10,
  parameter int P_WAIT   = 0
) (
  input  logic        I_AHBSLV_HCLK,
  input  logic        I_AHBSLV_HRESET_N,
  input  logic        I_AHBSLV_HSEL,
  input  logic [31:0] I_AHBSLV_HADDR,
  input  logic [1:0]  I_AHBSLV_HTRANS,
  input  logic        I_AHBSLV_HWRITE,
  input  logic [2:0]  I_AHBSLV_HSIZE,
  input  logic [2:0]  I_AHBSLV_HBURST,
  input  logic [31:0] I_AHBSLV_HWDATA,
  input  logic        I_AHBSLV_HREADY,
  output logic [31:0] O_AHBSLV_HRDATA,
  output logic        O_AHBSLV_HREADYOUT,
  output logic [1:0]  O_AHBSLV_HRESP
);

  localparam int DEPTH = 1 << P_ADDR_W;
  localparam logic [3:0] WAIT_INIT = (P_WAIT > 0) ? 4'(P_WAIT - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 load;
  logic                 accept;
  logic                 illegal;
  logic [P_ADDR_W-1:0]  word_q;
  logic [1:0]           lane_q;
  logic [1:0]           size_q;
  logic                 write_q;
  logic [3:0]           byte_en;
  logic [31:0]          mem [0:DEPTH-1];

  // Burst type and the SEQ/NSEQ distinction carry no meaning here: each beat stands alone.
  logic unused_inputs;
  assign unused_inputs = ^{I_AHBSLV_HBURST, I_AHBSLV_HTRANS[0]};

  assign accept  = I_AHBSLV_HSEL & I_AHBSLV_HREADY & I_AHBSLV_HTRANS[1];
  assign illegal = (I_AHBSLV_HSIZE > 3'd2)
                 | ((I_AHBSLV_HSIZE == 3'd1) & I_AHBSLV_HADDR[0])
                 | ((I_AHBSLV_HSIZE == 3'd2) & (I_AHBSLV_HADDR[1:0] != 2'b00))
                 | (I_AHBSLV_HADDR[31:P_ADDR_W+2] != '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    case (state)
      S_IDLE, S_LAST, S_ERR2: begin
        if (I_AHBSLV_HREADY) begin
          if (accept) begin
            load = 1'b1;
            if (illegal) begin
              state_nxt = S_ERR1;
            end else if (P_WAIT == 0) begin
              state_nxt = S_LAST;
            end else begin
              state_nxt = S_WAIT;
              cnt_nxt   = WAIT_INIT;
            end
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else             state_nxt = S_LAST;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_AHBSLV_HCLK or negedge I_AHBSLV_HRESET_N) begin
    if (!I_AHBSLV_HRESET_N) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      word_q  <= '0;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        word_q  <= I_AHBSLV_HADDR[P_ADDR_W+1:2];
        lane_q  <= I_AHBSLV_HADDR[1:0];
        size_q  <= I_AHBSLV_HSIZE[1:0];
        write_q <= I_AHBSLV_HWRITE;
      end
    end
  end

  always_comb begin
    byte_en = 4'b1111;
    case (size_q)
      2'd0:    byte_en = 4'b0001 << lane_q;
      2'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // The write commits on the edge that ends the completing cycle, so a read issued
  // back-to-back behind it already sees the new word.
  always_ff @(posedge I_AHBSLV_HCLK) begin
    if ((state == S_LAST) && I_AHBSLV_HREADY && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_q][8*i +: 8] <= I_AHBSLV_HWDATA[8*i +: 8];
      end
    end
  end

  assign O_AHBSLV_HRDATA    = ((state == S_LAST) && !write_q) ? mem[word_q] : 32'h0;
  assign O_AHBSLV_HREADYOUT = !((state == S_WAIT) || (state == S_ERR1));
  assign O_AHBSLV_HRESP     = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ahbslv_mem.sv
// Directed bench for ahbslv_mem: one zero-wait instance and one two-wait instance share the
// bus; the active instance is chosen by HSEL and drives the bus HREADY back to both.
module tb_ahbslv_mem;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        useTwo;

  logic [31:0] hrdata0, hrdata2;
  logic        hreadyout0, hreadyout2;
  logic [1:0]  hresp0, hresp2;

  int vectors;
  int miscompares;
  logic [31:0] patt [4];

  assign hready = useTwo ? hreadyout2 : hreadyout0;

  ahbslv_mem #(.P_ADDR_W(10), .P_WAIT(0)) dut0 (
    .I_AHBSLV_HCLK      (clk),
    .I_AHBSLV_HRESET_N  (rst_n),
    .I_AHBSLV_HSEL      (hsel & ~useTwo),
    .I_AHBSLV_HADDR     (haddr),
    .I_AHBSLV_HTRANS    (htrans),
    .I_AHBSLV_HWRITE    (hwrite),
    .I_AHBSLV_HSIZE     (hsize),
    .I_AHBSLV_HBURST    (hburst),
    .I_AHBSLV_HWDATA    (hwdata),
    .I_AHBSLV_HREADY    (hready),
    .O_AHBSLV_HRDATA    (hrdata0),
    .O_AHBSLV_HREADYOUT (hreadyout0),
    .O_AHBSLV_HRESP     (hresp0)
  );

  ahbslv_mem #(.P_ADDR_W(10), .P_WAIT(2)) dut2 (
    .I_AHBSLV_HCLK      (clk),
    .I_AHBSLV_HRESET_N  (rst_n),
    .I_AHBSLV_HSEL      (hsel & useTwo),
    .I_AHBSLV_HADDR     (haddr),
    .I_AHBSLV_HTRANS    (htrans),
    .I_AHBSLV_HWRITE    (hwrite),
    .I_AHBSLV_HSIZE     (hsize),
    .I_AHBSLV_HBURST    (hburst),
    .I_AHBSLV_HWDATA    (hwdata),
    .I_AHBSLV_HREADY    (hready),
    .O_AHBSLV_HRDATA    (hrdata2),
    .O_AHBSLV_HREADYOUT (hreadyout2),
    .O_AHBSLV_HRESP     (hresp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] tr, input logic wr,
                               input logic [31:0] a, input logic [2:0] sz);
    hsel   = sel;
    htrans = tr;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // INCR4 on the two-wait instance at 0x100; counts data cycles per beat up to a bound.
  task automatic incr4(input logic wr, input string name);
    int total;
    int cyc;
    bit done;
    total = 0;
    hburst = 3'b011;
    applyStimulus(1'b1, T_NSEQ, wr, 32'h100, 3'd2);
    tick();
    for (int b = 0; b < 4; b++) begin
      hwdata = patt[b];
      if (b < 3) applyStimulus(1'b1, T_SEQ, wr, 32'h100 + 32'(4 * (b + 1)), 3'd2);
      else       applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2);
      cyc  = 0;
      done = 1'b0;
      while (!done) begin
        cyc++;
        total++;
        if (hreadyout2 === 1'b1) done = 1'b1;
        else if (cyc >= 8)       done = 1'b1;
        else                     tick();
      end
      checkOutput($sformatf("%s_beat%0d_cycles", name, b), 32'(cyc), 32'd3);
      if (!wr) checkOutput($sformatf("%s_beat%0d_rdata", name, b), hrdata2, patt[b]);
      tick();
    end
    checkOutput({name, "_total_cycles"}, 32'(total), 32'd12);
    hburst = 3'b000;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    useTwo      = 1'b0;
    rst_n       = 1'b0;
    hwdata      = 32'h0;
    hburst      = 3'b000;
    applyStimulus(1'b0, T_IDLE, 1'b0, 32'h0, 3'd2);
    patt[0] = 32'h11112222;
    patt[1] = 32'h33334444;
    patt[2] = 32'h55556666;
    patt[3] = 32'h77778888;

    #1;
    checkOutput("rst_hreadyout", {31'h0, hreadyout0}, 32'h1);
    checkOutput("rst_hresp", {30'h0, hresp0}, 32'h0);
    checkOutput("rst_hrdata", hrdata0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Word write then back-to-back read of the same word
    applyStimulus(1'b1, T_NSEQ, 1'b1, 32'h10, 3'd2);
    tick();
    hwdata = 32'hDEADBEEF;
    applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2);
    checkOutput("b2b_wr_hreadyout", {31'h0, hreadyout0}, 32'h1);
    tick();
    applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2);
    checkOutput("b2b_rd_hreadyout", {31'h0, hreadyout0}, 32'h1);
    checkOutput("b2b_rd_hrdata", hrdata0, 32'hDEADBEEF);
    tick();
    checkOutput("idle_hrdata", hrdata0, 32'h0);

    // Byte lane 3 write, then halfword upper write
    applyStimulus(1'b1, T_NSEQ, 1'b1, 32'h13, 3'd0);
    tick();
    hwdata = 32'hAA000000;
    applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2);
    tick();
    applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2);
    checkOutput("byte_wr_rdata", hrdata0, 32'hAAADBEEF);
    tick();
    applyStimulus(1'b1, T_NSEQ, 1'b1, 32'h12, 3'd1);
    tick();
    hwdata = 32'h55550000;
    applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2);
    tick();
    applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2);
    checkOutput("half_wr_rdata", hrdata0, 32'h5555BEEF);
    tick();

    // Misaligned word write gives the two-cycle ERROR and leaves memory alone
    applyStimulus(1'b1, T_NSEQ, 1'b1, 32'h20, 3'd2);
    tick();
    hwdata = 32'h12345678;
    applyStimulus(1'b1, T_NSEQ, 1'b1, 32'h22, 3'd2);
    tick();
    hwdata = 32'hFFFFFFFF;
    applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2);
    checkOutput("err1_hreadyout", {31'h0, hreadyout0}, 32'h0);
    checkOutput("err1_hresp", {30'h0, hresp0}, 32'h1);
    tick();
    checkOutput("err2_hreadyout", {31'h0, hreadyout0}, 32'h1);
    checkOutput("err2_hresp", {30'h0, hresp0}, 32'h1);
    tick();
    checkOutput("post_err_hresp", {30'h0, hresp0}, 32'h0);
    applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h20, 3'd2);
    tick();
    applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2);
    checkOutput("err_word_unchanged", hrdata0, 32'h12345678);
    tick();

    // Out-of-range address and illegal size
    applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h1000, 3'd2);
    tick();
    applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2);
    checkOutput("range_err1", {30'h0, hresp0, hreadyout0}, 32'h2);
    tick();
    checkOutput("range_err2", {30'h0, hresp0, hreadyout0}, 32'h3);
    tick();
    applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h0, 3'd3);
    tick();
    applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2);
    checkOutput("size_err1", {30'h0, hresp0, hreadyout0}, 32'h2);
    tick();
    checkOutput("size_err2", {30'h0, hresp0, hreadyout0}, 32'h3);
    tick();

    // IDLE, BUSY and deselected NSEQ writes must not touch memory
    hwdata = 32'h0BADF00D;
    applyStimulus(1'b1, T_IDLE, 1'b1, 32'h10, 3'd2);
    tick();
    checkOutput("idle_okay", {30'h0, hresp0, hreadyout0}, 32'h1);
    applyStimulus(1'b1, T_BUSY, 1'b1, 32'h10, 3'd2);
    tick();
    checkOutput("busy_okay", {30'h0, hresp0, hreadyout0}, 32'h1);
    applyStimulus(1'b0, T_NSEQ, 1'b1, 32'h10, 3'd2);
    tick();
    checkOutput("nosel_okay", {30'h0, hresp0, hreadyout0}, 32'h1);
    applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h10, 3'd2);
    tick();
    applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2);
    checkOutput("no_access_unchanged", hrdata0, 32'h5555BEEF);
    tick();

    // Two-wait instance: INCR4 write then INCR4 read
    useTwo = 1'b1;
    tick();
    incr4(1'b1, "incr4_wr");
    incr4(1'b0, "incr4_rd");

    // Reset asserted during a wait state releases HREADYOUT without a clock edge
    applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h100, 3'd2);
    tick();
    applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 3'd2);
    checkOutput("wait_hreadyout", {31'h0, hreadyout2}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_hreadyout", {31'h0, hreadyout2}, 32'h1);
    checkOutput("async_rst_hresp", {30'h0, hresp2}, 32'h0);
    checkOutput("async_rst_hrdata", hrdata2, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
